// File: rtl/video_crtc_prog.sv
// Programmable CRT controller: register-file timing, VRAM address/row/dot generation,
// sync/blank and retrace status. Every output is registered one cycle behind the counters.
module video_crtc_prog #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 11,
    parameter int RA_W   = 5
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iRegWr,
    input  logic [3:0]        iRegIdx,
    input  logic [15:0]       iRegData,
    output logic [ADDR_W-1:0] oAddr,
    output logic [RA_W-1:0]   oRA,
    output logic [2:0]        oDA,
    output logic              oHs,
    output logic              oVs,
    output logic              oBlank,
    output logic              oVRetrace,
    output logic              oFrameStart
);

    logic [CNT_W-1:0]  htotal, hdisp, hss, hse;
    logic [CNT_W-1:0]  vtotal, vdisp, vss, vse;
    logic [CNT_W-1:0]  lcmp;
    logic [ADDR_W-1:0] start_addr, offset;
    logic [RA_W-1:0]   maxscan;
    logic [3:0]        mode;

    logic [CNT_W-1:0]  x, y, y_next;
    logic [ADDR_W-1:0] rowaddr;
    logic [RA_W-1:0]   ra;

    logic              hdouble, vdouble, hs_pos, vs_neg;
    logic              x_wrap, frame_wrap, line_end;
    logic              hs_active, vs_active;
    logic [CNT_W-1:0]  col;
    logic [2:0]        da;

    assign hdouble = mode[0];
    assign vdouble = mode[1];
    assign hs_pos  = mode[2];
    assign vs_neg  = mode[3];

    // ">=" rather than "==" so lowering a total below the live counter wraps at once.
    assign x_wrap     = (x >= htotal);
    assign frame_wrap = x_wrap && (y >= vtotal);
    assign y_next     = frame_wrap ? '0 : (x_wrap ? y + CNT_W'(1) : y);
    assign line_end   = x_wrap && (!vdouble || y[0]);

    assign hs_active = (x >= hss) && (x < hse);
    assign vs_active = (y >= vss) && (y < vse);
    assign col       = hdouble ? (x >> 4) : (x >> 3);
    assign da        = hdouble ? x[3:1] : x[2:0];

    always_ff @(posedge iClk) begin
        if (iRst) begin
            htotal     <= CNT_W'(799);
            hdisp      <= CNT_W'(640);
            hss        <= CNT_W'(656);
            hse        <= CNT_W'(752);
            vtotal     <= CNT_W'(448);
            vdisp      <= CNT_W'(400);
            vss        <= CNT_W'(412);
            vse        <= CNT_W'(414);
            start_addr <= '0;
            offset     <= ADDR_W'(40);
            maxscan    <= '0;
            mode       <= 4'h3;
            lcmp       <= '1;
        end else if (iRegWr) begin
            case (iRegIdx)
                4'd0:    htotal     <= iRegData[CNT_W-1:0];
                4'd1:    hdisp      <= iRegData[CNT_W-1:0];
                4'd2:    hss        <= iRegData[CNT_W-1:0];
                4'd3:    hse        <= iRegData[CNT_W-1:0];
                4'd4:    vtotal     <= iRegData[CNT_W-1:0];
                4'd5:    vdisp      <= iRegData[CNT_W-1:0];
                4'd6:    vss        <= iRegData[CNT_W-1:0];
                4'd7:    vse        <= iRegData[CNT_W-1:0];
                4'd8:    start_addr <= iRegData[ADDR_W-1:0];
                4'd9:    offset     <= iRegData[ADDR_W-1:0];
                4'd10:   maxscan    <= iRegData[RA_W-1:0];
                4'd11:   mode       <= iRegData[3:0];
                4'd12:   lcmp       <= iRegData[CNT_W-1:0];
                default: ;
            endcase
        end
    end

    // rowaddr itself is the frame's START shadow: it only samples START at the wrap.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            x       <= '0;
            y       <= '0;
            rowaddr <= '0;
            ra      <= '0;
        end else begin
            x <= x_wrap ? '0 : x + CNT_W'(1);
            y <= y_next;
            if (frame_wrap) begin
                rowaddr <= start_addr;
                ra      <= '0;
            end else if (x_wrap && (y_next == lcmp)) begin
                rowaddr <= '0;
                ra      <= '0;
            end else if (line_end) begin
                if (ra == maxscan) begin
                    ra      <= '0;
                    rowaddr <= rowaddr + offset;
                end else begin
                    ra <= ra + RA_W'(1);
                end
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            oAddr       <= '0;
            oRA         <= '0;
            oDA         <= '0;
            oHs         <= 1'b1;
            oVs         <= 1'b0;
            oBlank      <= 1'b1;
            oVRetrace   <= 1'b0;
            oFrameStart <= 1'b0;
        end else begin
            oAddr       <= rowaddr + ADDR_W'(col);
            oRA         <= ra;
            oDA         <= da;
            oBlank      <= (x >= hdisp) || (y >= vdisp);
            oHs         <= hs_active ^ ~hs_pos;
            oVs         <= vs_active ^ vs_neg;
            oVRetrace   <= vs_active;
            oFrameStart <= (x == '0) && (y == '0);
        end
    end

endmodule

// File: tb/tb_video_crtc_prog.sv
// Directed bench for video_crtc_prog: defaults, live HTOTAL change, reset, then a
// reprogrammed 100x30 mode to exercise scan rows, sync, START shadowing and line compare.
module tb_video_crtc_prog;

    logic        iClk = 1'b0;
    logic        iRst = 1'b1;
    logic        iRegWr = 1'b0;
    logic [3:0]  iRegIdx = '0;
    logic [15:0] iRegData = '0;
    logic [15:0] oAddr;
    logic [4:0]  oRA;
    logic [2:0]  oDA;
    logic        oHs, oVs, oBlank, oVRetrace, oFrameStart;

    int total = 0;
    int bad   = 0;
    int rel   = 0;
    logic [15:0] exp_q[$];

    video_crtc_prog dut (
        .iClk(iClk), .iRst(iRst), .iRegWr(iRegWr), .iRegIdx(iRegIdx), .iRegData(iRegData),
        .oAddr(oAddr), .oRA(oRA), .oDA(oDA), .oHs(oHs), .oVs(oVs), .oBlank(oBlank),
        .oVRetrace(oVRetrace), .oFrameStart(oFrameStart)
    );

    always #5 iClk = ~iClk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // rel n: outputs describe counter position n of the current frame.
    task automatic tick();
        @(posedge iClk);
        #1;
        rel++;
    endtask

    task automatic adv(input int n);
        while (rel < n) tick();
    endtask

    task automatic wr(input logic [3:0] idx, input logic [15:0] data);
        iRegWr   = 1'b1;
        iRegIdx  = idx;
        iRegData = data;
        tick();
        iRegWr   = 1'b0;
    endtask

    task automatic wait_frame(input int bound);
        int n = 0;
        do begin
            tick();
            n++;
        end while (oFrameStart !== 1'b1 && n < bound);
        chk("frame_seen", {31'd0, oFrameStart}, 32'd1);
        rel = 0;
    endtask

    // Small mode frames are 100 x 30 = 3000 cycles.
    task automatic next_frame(input string tag);
        logic [15:0] e;
        adv(2999);
        chk({tag, "_pre"}, {31'd0, oFrameStart}, 32'd0);
        adv(3000);
        chk({tag, "_fs"}, {31'd0, oFrameStart}, 32'd1);
        e = exp_q.pop_front();
        chk({tag, "_addr"}, {16'd0, oAddr}, {16'd0, e});
        rel = 0;
    endtask

    initial begin
        exp_q.push_back(16'h1000);
        exp_q.push_back(16'h1000);
        exp_q.push_back(16'h3000);
        exp_q.push_back(16'h2000);
        exp_q.push_back(16'h2000);

        repeat (3) tick();
        chk("rst_addr", {16'd0, oAddr}, 32'd0);
        chk("rst_ra", {27'd0, oRA}, 32'd0);
        chk("rst_da", {29'd0, oDA}, 32'd0);
        chk("rst_hs", {31'd0, oHs}, 32'd1);
        chk("rst_vs", {31'd0, oVs}, 32'd0);
        chk("rst_blank", {31'd0, oBlank}, 32'd1);
        chk("rst_vr", {31'd0, oVRetrace}, 32'd0);
        chk("rst_fs", {31'd0, oFrameStart}, 32'd0);

        // Default 800x449 timing, vdouble+hdouble
        iRst = 1'b0;
        tick();
        rel = 0;
        chk("def_fs0", {31'd0, oFrameStart}, 32'd1);
        chk("def_blank0", {31'd0, oBlank}, 32'd0);
        chk("def_hs0", {31'd0, oHs}, 32'd1);
        adv(1);    chk("def_fs1", {31'd0, oFrameStart}, 32'd0);
        adv(15);   chk("def_addr15", {16'd0, oAddr}, 32'd0);
        chk("def_da15", {29'd0, oDA}, 32'd7);
        adv(16);   chk("def_addr16", {16'd0, oAddr}, 32'd1);
        chk("def_da16", {29'd0, oDA}, 32'd0);
        adv(639);  chk("def_blank639", {31'd0, oBlank}, 32'd0);
        adv(640);  chk("def_blank640", {31'd0, oBlank}, 32'd1);
        adv(655);  chk("def_hs655", {31'd0, oHs}, 32'd1);
        adv(656);  chk("def_hs656", {31'd0, oHs}, 32'd0);
        adv(751);  chk("def_hs751", {31'd0, oHs}, 32'd0);
        adv(752);  chk("def_hs752", {31'd0, oHs}, 32'd1);
        adv(800);  chk("def_line1", {16'd0, oAddr}, 32'd0);
        adv(1600); chk("def_line2", {16'd0, oAddr}, 32'd40);
        adv(1635); chk("def_l2_addr", {16'd0, oAddr}, 32'd42);
        chk("def_l2_da", {29'd0, oDA}, 32'd1);

        // Counter is at x=500 of line 2 during this write; HTOTAL=100 forces a wrap after x=501.
        adv(2099);
        wr(4'd0, 16'd100);
        tick();
        chk("ht_x501", {16'd0, oAddr}, 32'd71);
        tick();
        chk("ht_l3_x0", {16'd0, oAddr}, 32'd40);
        chk("ht_l3_da", {29'd0, oDA}, 32'd0);
        adv(2202); chk("ht_l3_x100", {16'd0, oAddr}, 32'd46);
        adv(2203); chk("ht_l4_x0", {16'd0, oAddr}, 32'd80);

        // Mid-line reset with a concurrent write that must be dropped.
        adv(2250);
        iRst = 1'b1;
        iRegWr = 1'b1;
        iRegIdx = 4'd0;
        iRegData = 16'd50;
        tick();
        iRst = 1'b0;
        iRegWr = 1'b0;
        chk("mrst_addr", {16'd0, oAddr}, 32'd0);
        chk("mrst_hs", {31'd0, oHs}, 32'd1);
        chk("mrst_blank", {31'd0, oBlank}, 32'd1);
        chk("mrst_fs", {31'd0, oFrameStart}, 32'd0);
        tick();
        rel = 0;
        chk("mrst_fs_pulse", {31'd0, oFrameStart}, 32'd1);
        adv(60);
        chk("mrst_ht_kept", {16'd0, oAddr}, 32'd3);
        chk("mrst_da", {29'd0, oDA}, 32'd6);

        // Small mode: 100 x 30, no doubling, 16-line cells, pitch 80.
        wr(4'd0, 16'd99);
        wr(4'd1, 16'd80);
        wr(4'd2, 16'd84);
        wr(4'd3, 16'd92);
        wr(4'd4, 16'd29);
        wr(4'd5, 16'd20);
        wr(4'd6, 16'd22);
        wr(4'd7, 16'd24);
        wr(4'd11, 16'h0);
        wr(4'd10, 16'd15);
        wr(4'd9, 16'd80);
        wait_frame(10000);

        chk("f1_addr0", {16'd0, oAddr}, 32'd0);
        chk("f1_ra0", {27'd0, oRA}, 32'd0);
        adv(13);   chk("f1_addr13", {16'd0, oAddr}, 32'd1);
        chk("f1_da13", {29'd0, oDA}, 32'd5);
        adv(79);   chk("f1_blank79", {31'd0, oBlank}, 32'd0);
        adv(80);   chk("f1_blank80", {31'd0, oBlank}, 32'd1);
        adv(83);   chk("f1_hs83", {31'd0, oHs}, 32'd1);
        adv(84);   chk("f1_hs84", {31'd0, oHs}, 32'd0);
        adv(91);   chk("f1_hs91", {31'd0, oHs}, 32'd0);
        adv(92);   chk("f1_hs92", {31'd0, oHs}, 32'd1);
        adv(500);  chk("f1_ra5", {27'd0, oRA}, 32'd5);
        chk("f1_addr_y5", {16'd0, oAddr}, 32'd0);
        adv(1500); chk("f1_ra15", {27'd0, oRA}, 32'd15);
        adv(1608); chk("f1_ra_y16", {27'd0, oRA}, 32'd0);
        chk("f1_addr_y16", {16'd0, oAddr}, 32'd81);
        adv(2000); chk("f1_vblank", {31'd0, oBlank}, 32'd1);
        adv(2010);
        wr(4'd8, 16'h1000);
        adv(2199); chk("f1_vs_y21", {31'd0, oVs}, 32'd0);
        chk("f1_vr_y21", {31'd0, oVRetrace}, 32'd0);
        adv(2200); chk("f1_vs_y22", {31'd0, oVs}, 32'd1);
        chk("f1_vr_y22", {31'd0, oVRetrace}, 32'd1);
        adv(2400); chk("f1_vs_y24", {31'd0, oVs}, 32'd0);
        adv(2516); chk("f1_addr_y25", {16'd0, oAddr}, 32'd82);
        next_frame("f2");

        // START written in the exact frame-wrap cycle is held off one frame.
        adv(2998);
        wr(4'd8, 16'h3000);
        next_frame("f3");
        next_frame("f4");

        adv(2000);
        wr(4'd8, 16'h2000);
        wr(4'd12, 16'd10);
        next_frame("f5");
        adv(900);  chk("f5_addr_y9", {16'd0, oAddr}, 32'h2000);
        chk("f5_ra_y9", {27'd0, oRA}, 32'd9);
        adv(1000); chk("f5_lcmp_addr", {16'd0, oAddr}, 32'd0);
        chk("f5_lcmp_ra", {27'd0, oRA}, 32'd0);
        adv(1016); chk("f5_lcmp_col", {16'd0, oAddr}, 32'd2);
        adv(1100); chk("f5_ra_y11", {27'd0, oRA}, 32'd1);
        adv(1500);
        wr(4'd12, 16'd0);
        next_frame("f6");
        chk("f6_ra0", {27'd0, oRA}, 32'd0);
        adv(100);  chk("f6_ra1", {27'd0, oRA}, 32'd1);
        chk("f6_addr_y1", {16'd0, oAddr}, 32'h2000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/video_crtc_prog.md
Name: video_crtc_prog

Overview:
Programmable CRTC, the successor to the fixed 640x400@70 EGA timing generator. All horizontal and vertical timing is held in a register file written by the IO decoder, which lets one instance serve text, EGA and VGA-style modes. Adds over the fixed generator: start address, row offset (pitch), programmable character height, independent pixel/line doubling, sync polarity, line-compare split screen and retrace status. Drives VRAM addressing and sync/blank for the attribute controller.

Parameters:
ADDR_W, 16, width of oAddr (VRAM word address).
CNT_W, 11, width of the x/y counters and timing registers.
RA_W, 5, width of the row address (character height up to 32).

Ports:
iClk  in  1  pixel clock; all logic is on its rising edge.
iRst  in  1  synchronous, active-high reset.
iRegWr  in  1  register write strobe, one cycle per write.
iRegIdx  in  4  register index.
iRegData  in  16  register write data (LSB-aligned, excess bits ignored).
oAddr  out  ADDR_W  VRAM address of the current character/byte.
oRA  out  RA_W  row address within the character cell.
oDA  out  3  dot address within the byte (0..7).
oHs  out  1  horizontal sync, polarity per MODE.
oVs  out  1  vertical sync, polarity per MODE.
oBlank  out  1  1 outside the visible area.
oVRetrace  out  1  1 while the y counter is in [VSYNC_START, VSYNC_END); feeds the 3DA status bit.
oFrameStart  out  1  one-cycle pulse at x=0, y=0.

Behaviour:
- Register map, with reset defaults:
  - 0 HTOTAL=799, last x value.
  - 1 HDISP=640, first blanked x.
  - 2 HSS=656, 3 HSE=752: HS active for HSS<=x<HSE.
  - 4 VTOTAL=448, last y value.
  - 5 VDISP=400.
  - 6 VSS=412, 7 VSE=414.
  - 8 START=0 (ADDR_W).
  - 9 OFFSET=40, added per character row.
  - 10 MAXSCAN=0 (RA_W), character height-1.
  - 11 MODE=0x3: bit0 hdouble, bit1 vdouble, bit2 hs_pos (0=negative pulse), bit3 vs_neg (0=positive pulse).
  - 12 LCMP=all-ones (disabled).
  - Writes to indices 13..15 are ignored.
- Register write timing: a write takes effect on the following cycle.
- START shadowing: START is copied into a shadow at every frame wrap. A write in the wrap cycle is not seen until the next frame.
- x counter: increments every cycle. When x>=HTOTAL it wraps to 0 and y advances. The >= compare means lowering HTOTAL below the current x wraps on the next cycle, with no 2^CNT_W runaway.
- y counter: wraps to 0 when y>=VTOTAL at an x wrap (frame wrap).
- Effective line: a line-end event occurs at every x wrap when vdouble=0, and only at x wraps with y[0]=1 when vdouble=1.
- Row state (rowaddr, ra):
  - Frame wrap: rowaddr<=START shadow, ra<=0.
  - Else, when the new y equals LCMP: rowaddr<=0, ra<=0.
  - Else, at a line-end event: if ra==MAXSCAN then ra<=0 and rowaddr+=OFFSET; otherwise ra++.
  - Priority is frame wrap > LCMP > line-end.
  - All addition is modulo 2^ADDR_W.
- Column decode:
  - col = x>>3 when hdouble=0, x>>4 when hdouble=1.
  - da = x[2:0] when hdouble=0, x[3:1] when hdouble=1.
- Output timing: every output is a flop, so output at cycle n+1 describes counter state at cycle n (latency 1 for all outputs).
  - oAddr = rowaddr+col.
  - oRA = ra.
  - oDA = da.
  - oBlank = (x>=HDISP) | (y>=VDISP).
  - oHs = hs_active ^ ~hs_pos.
  - oVs = vs_active ^ vs_neg.
  - oVRetrace = vs_active.
  - oFrameStart = (x==0 && y==0).
- Reset:
  - x=y=0, ra=0, rowaddr=0, shadow=0, all registers at their defaults.
  - Outputs after reset: oAddr=0, oRA=0, oDA=0, oHs=1, oVs=0, oBlank=1, oVRetrace=0, oFrameStart=0.
  - The first cycle after iRst deasserts presents x=0, y=0, so oFrameStart=1 one cycle later.
  - Reset mid-frame restarts timing immediately. A register write in the same cycle as iRst is discarded.
- Degenerate settings:
  - HSE<=HSS gives no HS pulse; VSE<=VSS likewise gives no VS pulse.
  - HDISP>HTOTAL means never blank horizontally.
  - MAXSCAN=0 advances rowaddr on every effective line.

Test Plan:
- Reset defaults, run 2 frames -> HS period 800 cycles, low for 96 cycles starting 657 cycles after x=0 (flop latency); VS high for 2 lines from line 412; frame = 449*800 = 359200 cycles; oFrameStart every 359200 cycles.
- Defaults, sample oAddr -> constant across x=0..15 and +1 every 16 cycles; line 0 and line 1 both start at 0; line 2 starts at 40; line 399 starts at 7960; oDA=x[3:1].
- Write MODE=0x0, MAXSCAN=15, OFFSET=80 -> oDA=x[2:0]; oRA counts 0..15 per line; rowaddr +80 every 16 lines; oAddr +1 every 8 pixels.
- Write START=0x1000 mid-frame -> current frame unchanged; next frame line 0 oAddr=0x1000. Write in the exact frame-wrap cycle -> applied one frame later.
- LCMP=200 with START=0x2000 -> lines 0..199 address from 0x2000; line 200 resets to oAddr=0, oRA=0; LCMP=0 -> frame wrap wins, address=START.
- Write HTOTAL=100 while x=500 -> x wraps next cycle. Assert iRst mid-line -> outputs return to their reset values, and oFrameStart pulses 2 cycles after iRst deasserts.
